// File: rtl/oai21_bist_ctrl.sv
// ---------------------------------------------------------------------------
// oai21_bist_ctrl
//   Built-in self-test controller for a switch-level OAI21 cell
//   (out = ~((a|b)&c)). Walks {a,b,c} through all eight vectors, waits
//   SETTLE cycles for the cell to settle, samples dut_out and compares it
//   with the golden function. Reports pass/fail, a mismatch count and the
//   first failing vector.
//
//   Optional feature macro: OAI21_BIST_SIG_EN
//     defined   -> 8-bit response signature register drives sig
//     undefined -> sig tied to 8'h00 (port kept for an identical interface)
//
//   start handshake: start is a level sampled only while the controller is
//   idle (IDLE or DONE). A high sample launches a run and clears all
//   previous results; while busy is high start is ignored. done stays high
//   until the next accepted start or a reset. rst overrides start.
//
//   SETTLE legal range is 1..15 (cnt is 4 bits wide).
// ---------------------------------------------------------------------------
module oai21_bist_ctrl #(
  parameter int unsigned SETTLE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_vec,
  output logic [7:0] sig,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Last cnt value spent in WAIT; WAIT therefore lasts SETTLE cycles and
  // each vector is held for SETTLE+1 cycles including SAMPLE.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic [2:0] fail_q, fail_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       exp_bit;
  logic       mismatch;

`ifdef OAI21_BIST_SIG_EN
  logic [7:0] sig_q, sig_d;
  logic       resp_one;
`endif

  // Golden OAI21 value for the vector currently applied, and the 4-state
  // comparison: X or Z from a floating cell output counts as a mismatch.
  always_comb begin
    exp_bit  = ~((vec_q[2] | vec_q[1]) & vec_q[0]);
    mismatch = (dut_out !== exp_bit);
  end

`ifdef OAI21_BIST_SIG_EN
  // Only a clean logic 1 feeds a 1 into the signature.
  always_comb begin
    resp_one = (dut_out === 1'b1);
  end
`endif

  // Next-state and next-result computation for the whole controller.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef OAI21_BIST_SIG_EN
    sig_d   = sig_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WAIT;
          vec_d   = 3'd0;
          cnt_d   = 4'd0;
          err_d   = 4'd0;
          fail_d  = 3'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef OAI21_BIST_SIG_EN
          sig_d   = 8'h00;
`endif
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        // At most eight mismatches per run, so the 4-bit count never wraps.
        if (mismatch) begin
          err_d = err_q + 4'd1;
          if (err_q == 4'd0) begin
            fail_d = vec_q;
          end
        end
`ifdef OAI21_BIST_SIG_EN
        sig_d = {sig_q[6:0],
                 sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3] ^ resp_one};
`endif
        if (vec_q == 3'd7) begin
          // Last vector: hold vec at 7 and publish the verdict together
          // with done so all results are stable on the same edge.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 4'd0);
        end else begin
          state_d = ST_WAIT;
          vec_d   = vec_q + 3'd1;
          cnt_d   = 4'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Single state/result register bank with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= 4'd0;
      err_q   <= 4'd0;
      fail_q  <= 3'd0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef OAI21_BIST_SIG_EN
      sig_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef OAI21_BIST_SIG_EN
      sig_q   <= sig_d;
`endif
    end
  end

  assign a         = vec_q[2];
  assign b         = vec_q[1];
  assign c         = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;
  assign dbg_state = state_q;

`ifdef OAI21_BIST_SIG_EN
  assign sig = sig_q;
`else
  assign sig = 8'h00;
`endif

endmodule

// File: tb/tb_oai21_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_oai21_bist_ctrl
//   Bench for oai21_bist_ctrl. A behavioural cell model answers the
//   controller's vectors; per run the expected verdict is computed from a
//   golden truth table and pushed to a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_oai21_bist_ctrl;

  localparam int SETTLE  = 3;
  localparam int RUN_CYC = 8 * (SETTLE + 1);

  // Cell model modes
  localparam int M_GOOD   = 0;  // golden ^ err_mask
  localparam int M_STUCK0 = 1;
  localparam int M_STUCK1 = 2;
  localparam int M_FLOAT  = 3;  // high impedance

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dut_out;
  logic       a, b, c;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] fail_vec;
  logic [7:0] sig;
  logic [1:0] dbg_state;

  int         mode;
  logic [7:0] err_mask;
  logic [7:0] gold_tab;   // bit v = OAI21 output for {a,b,c}=v

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];      // {pass, err_count, fail_vec}
  logic [7:0] exp_sig_q[$];

  typedef struct {
    int         mode;
    logic [7:0] mask;
    logic [3:0] err;
    logic [2:0] fail;
    logic       pass;
  } vec_rec_t;

  vec_rec_t tab[5];

  oai21_bist_ctrl #(.SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dut_out   (dut_out),
    .a         (a),
    .b         (b),
    .c         (c),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec),
    .sig       (sig),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- cell model ----------------
  function automatic logic cell_val(input int m, input logic [7:0] mask,
                                    input logic [2:0] v);
    logic r;
    case (m)
      M_STUCK0: r = 1'b0;
      M_STUCK1: r = 1'b1;
      M_FLOAT:  r = 1'bz;
      default:  r = gold_tab[v] ^ mask[v];
    endcase
    return r;
  endfunction

  always_comb dut_out = cell_val(mode, err_mask, {a, b, c});

  // ---------------- reference model ----------------
  task automatic predict();
    int         n;
    logic [2:0] first;
    logic [7:0] s;
    logic       d;
    n = 0; first = 3'd0; s = 8'h00;
    for (int v = 0; v < 8; v++) begin
      d = cell_val(mode, err_mask, 3'(v));
      if (d !== gold_tab[v]) begin
        if (n == 0) first = 3'(v);
        n++;
      end
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3] ^ (d === 1'b1)};
    end
    exp_q.push_back({(n == 0), 4'(n), first});
`ifdef OAI21_BIST_SIG_EN
    exp_sig_q.push_back(s);
`else
    exp_sig_q.push_back(8'h00);
`endif
  endtask

  // ---------------- check helper ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " abc"},  {a, b, c}, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " pass"}, pass, 0);
    chk({tag, " err"},  err_count, 0);
    chk({tag, " fail"}, fail_vec, 0);
    chk({tag, " sig"},  sig, 0);
  endtask

  // ---------------- driver: one full run ----------------
  // glitch_at > 0 pulses start for one cycle at that point in the run.
  task automatic run(input string tag, input int glitch_at);
    int         n;
    int         bad_vec;
    int         bad_busy;
    int         want;
    logic [7:0] e;
    logic [7:0] es;
    predict();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, " start busy"}, busy, 1);
    chk({tag, " start done"}, done, 0);
    chk({tag, " start cleared"}, {pass, err_count, fail_vec}, 0);
    n = 0; bad_vec = 0; bad_busy = 0;
    while (!done && n < RUN_CYC + 20) begin
      @(posedge clk);
      #1;
      n++;
      start = (glitch_at != 0 && n == glitch_at);
      want = (n < RUN_CYC) ? n / (SETTLE + 1) : 7;
      if ({a, b, c} != 3'(want)) bad_vec++;
      if (n < RUN_CYC && busy !== 1'b1) bad_busy++;
    end
    start = 1'b0;
    chk({tag, " latency"}, n, RUN_CYC);
    chk({tag, " vec seq errs"}, bad_vec, 0);
    chk({tag, " busy errs"}, bad_busy, 0);
    chk({tag, " busy end"}, busy, 0);
    e  = exp_q.pop_front();
    es = exp_sig_q.pop_front();
    chk({tag, " pass"}, pass, e[7]);
    chk({tag, " err_count"}, err_count, e[6:3]);
    chk({tag, " fail_vec"}, fail_vec, e[2:0]);
    chk({tag, " sig"}, sig, es);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    gold_tab = 8'h57;
    mode     = M_GOOD;
    err_mask = 8'h00;
    rst      = 1'b1;
    start    = 1'b0;

    tab[0] = '{M_GOOD,   8'h00, 4'd0, 3'd0, 1'b1};
    tab[1] = '{M_STUCK0, 8'h00, 4'd5, 3'd0, 1'b0};
    tab[2] = '{M_STUCK1, 8'h00, 4'd3, 3'd3, 1'b0};
    tab[3] = '{M_GOOD,   8'h20, 4'd1, 3'd5, 1'b0};
    tab[4] = '{M_GOOD,   8'h81, 4'd2, 3'd0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("idle");

    // Directed table rows with hand-derived expected verdicts
    foreach (tab[i]) begin
      mode     = tab[i].mode;
      err_mask = tab[i].mask;
      run($sformatf("tab%0d", i), 0);
      chk($sformatf("tab%0d const err", i),  err_count, tab[i].err);
      chk($sformatf("tab%0d const fail", i), fail_vec,  tab[i].fail);
      chk($sformatf("tab%0d const pass", i), pass,      tab[i].pass);
    end

    // Good cell gives the known signature when the feature is built
    mode = M_GOOD; err_mask = 8'h00;
    run("good2", 0);
`ifdef OAI21_BIST_SIG_EN
    chk("good sig const", sig, 8'hE0);
`else
    chk("good sig const", sig, 8'h00);
`endif

    // Floating cell output
    mode = M_FLOAT;
    run("float", 0);

    // start pulsed during WAIT is ignored
    mode = M_GOOD; err_mask = 8'h10;
    run("glitch", 2);

    // Randomized fault masks, sometimes with a mid-run start pulse
    for (int i = 0; i < 8; i++) begin
      mode     = M_GOOD;
      err_mask = 8'($urandom_range(0, 255));
      run($sformatf("rand%0d", i),
          ($urandom_range(0, 1) == 1) ? $urandom_range(1, RUN_CYC - 1) : 0);
    end

    // Reset while vector 4 is applied aborts the run
    mode = M_STUCK0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4 * (SETTLE + 1)) @(negedge clk);
    chk("mid vec is 4", {a, b, c}, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    mode = M_GOOD; err_mask = 8'h00;
    run("after rst", 0);

    // rst and start together: rst wins
    mode = M_STUCK1;
    run("pre both", 0);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    check_reset("both");
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_reset("both idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
